// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Holds forwarding-select codes, the memory-wait FSM states and the timeout limit.
// Also provides the EX-over-MEM forwarding priority helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  localparam logic [7:0] MEM_TIMEOUT = 8'd255;

  // The youngest writer (EX) wins over the older one (MEM).
  function automatic fwd_sel_t fwd_pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit) begin
      return FWD_EX;
    end else if (mem_hit) begin
      return FWD_MEM;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Register dependency comparator for one source/writer pair.
// Purely combinational, zero latency.
// x0 is hardwired zero, so a write to it never creates a dependency.
module hazard_match (
  input  logic [4:0] rs,
  input  logic [4:0] wr,
  input  logic       we,
  input  logic       use_rs,
  output logic       hit
);

  assign hit = use_rs && we && (wr != 5'd0) && (rs == wr);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stalls, branch flushes, memory-wait freeze with timeout.
// Stall/flush outputs are combinational (zero latency); forwarding selects are registered (1 cycle).
// Forwarding is built only when PIPE_HAZARD_CTRL_FWD_EN is defined; otherwise every RAW hit stalls.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_wr,
  input  logic        ex_we,
  input  logic        ex_is_load,
  input  logic [4:0]  mem_wr,
  input  logic        mem_we,
  input  logic        ex_br_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_bubble,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt
);

  logic   rs1_ex_hit, rs2_ex_hit, rs1_mem_hit, rs2_mem_hit;
  logic   load_use, data_haz, frozen;
  state_t state_q, state_d;
  logic [7:0]  wait_q, wait_d, wait_inc;
  logic [15:0] stall_cnt_q;

  hazard_match u_rs1_ex  (.rs(id_rs1), .wr(ex_wr),  .we(ex_we),  .use_rs(id_use_rs1), .hit(rs1_ex_hit));
  hazard_match u_rs2_ex  (.rs(id_rs2), .wr(ex_wr),  .we(ex_we),  .use_rs(id_use_rs2), .hit(rs2_ex_hit));
  hazard_match u_rs1_mem (.rs(id_rs1), .wr(mem_wr), .we(mem_we), .use_rs(id_use_rs1), .hit(rs1_mem_hit));
  hazard_match u_rs2_mem (.rs(id_rs2), .wr(mem_wr), .we(mem_we), .use_rs(id_use_rs2), .hit(rs2_mem_hit));

  assign load_use = ex_is_load && (rs1_ex_hit || rs2_ex_hit);

`ifdef PIPE_HAZARD_CTRL_FWD_EN
  // With forwarding, only a load in EX cannot supply its result in time.
  assign data_haz = load_use;
`else
  // Without forwarding, any in-flight writer must drain first; load hits are a subset.
  assign data_haz = load_use || rs1_ex_hit || rs2_ex_hit || rs1_mem_hit || rs2_mem_hit;
`endif

  assign wait_inc = wait_q + 8'd1;

  // Memory-wait FSM next state plus the stall/flush priority: freeze > branch flush > data hazard.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    frozen        = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;

    case (state_q)
      ST_RUN: begin
        wait_d = 8'd0;
        // An ack in the same cycle as the request completes without a freeze.
        if (mem_req && !mem_ack) begin
          frozen  = 1'b1;
          state_d = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          wait_d  = 8'd0;
          state_d = ST_RUN;
        end else begin
          frozen = 1'b1;
          wait_d = wait_inc;
          if (wait_inc == MEM_TIMEOUT) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        frozen = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = 8'd0;
      end
    endcase

    if (frozen) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (ex_br_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (data_haz) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // FSM state and wait counter registers; only reset leaves ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else if (pc_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign mem_timeout = (state_q == ST_ERR);

`ifdef PIPE_HAZARD_CTRL_FWD_EN
  fwd_sel_t fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  // Next operand selects; a bubble entering EX must not forward anything.
  always_comb begin
    fwd_a_d = fwd_pick(rs1_ex_hit, rs1_mem_hit);
    fwd_b_d = fwd_pick(rs2_ex_hit, rs2_mem_hit);
    if (id_ex_flush) begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end
  end

  // Selects follow the instruction into EX, so they hold while the pipe is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!frozen) begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
`else
  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations adapt to PIPE_HAZARD_CTRL_FWD_EN.
// Inputs change 1 ns after the rising edge; outputs are sampled before the next edge.
// Control outputs are compared as {pc,if_id,id_ex,ex_mem stall, if_id,id_ex flush, mem_wb bubble}.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_LU     = 7'b1100010;
  localparam logic [6:0] C_BR     = 7'b0000110;
  localparam logic [6:0] C_FREEZE = 7'b1111001;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_wr, mem_wr;
  logic        id_use_rs1, id_use_rs2, ex_we, ex_is_load, mem_we;
  logic        ex_br_taken, mem_req, mem_ack;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout;
  logic [15:0] stall_cnt;
  logic [6:0]  ctl;

  int n_chk = 0;
  int n_err = 0;
  int exp_sc = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_bubble};

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_wr(ex_wr), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .mem_wr(mem_wr), .mem_we(mem_we),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_wr = 5'd0; ex_we = 1'b0; ex_is_load = 1'b0;
    mem_wr = 5'd0; mem_we = 1'b0;
    ex_br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  // Check the combinational controls for the current inputs, clock once, check the stall counter.
  task automatic step(input string tag, input logic [6:0] exp_ctl);
    #1;
    chk({tag, "/ctl"}, {25'd0, ctl}, {25'd0, exp_ctl});
    if (exp_ctl[6]) exp_sc++;
    @(posedge clk);
    #1;
    chk({tag, "/scnt"}, {16'd0, stall_cnt}, exp_sc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_sc = 0;
  endtask

  initial begin
    do_reset();
    chk("rst/fwd_a", {30'd0, fwd_a_sel}, 0);
    chk("rst/fwd_b", {30'd0, fwd_b_sel}, 0);
    chk("rst/tmo",   {31'd0, mem_timeout}, 0);
    chk("rst/scnt",  {16'd0, stall_cnt}, 0);
    step("idle", C_NONE);

    // ALU result in EX feeding rs1
    ex_wr = 5'd5; ex_we = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    step("ex_raw", FWD ? C_NONE : C_LU);
    chk("ex_raw/fwd_a", {30'd0, fwd_a_sel}, FWD ? 1 : 0);

    // x0 writer never matches, even as a load
    clear_in();
    ex_wr = 5'd0; ex_we = 1'b1; ex_is_load = 1'b1; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    step("x0", C_NONE);
    chk("x0/fwd_a", {30'd0, fwd_a_sel}, 0);

    // index matches but ID does not read rs2, then writer disabled
    clear_in();
    ex_wr = 5'd3; ex_we = 1'b1; ex_is_load = 1'b1; id_rs2 = 5'd3;
    step("nouse", C_NONE);
    id_use_rs2 = 1'b1; ex_we = 1'b0;
    step("nowe", C_NONE);

    // MEM writer feeding rs2
    clear_in();
    mem_wr = 5'd9; mem_we = 1'b1; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    step("mem_raw", FWD ? C_NONE : C_LU);
    chk("mem_raw/fwd_b", {30'd0, fwd_b_sel}, FWD ? 2 : 0);

    // both writers target rs2: EX is younger and wins
    ex_wr = 5'd9; ex_we = 1'b1;
    step("prio", FWD ? C_NONE : C_LU);
    chk("prio/fwd_b", {30'd0, fwd_b_sel}, FWD ? 1 : 0);

    // lw x7 in EX, ID reads rs2=x7
    clear_in();
    ex_wr = 5'd7; ex_we = 1'b1; ex_is_load = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    step("ldu", C_LU);
    chk("ldu/fwd_b", {30'd0, fwd_b_sel}, 0);
    ex_we = 1'b0; ex_is_load = 1'b0; mem_wr = 5'd7; mem_we = 1'b1;
    step("ldu2", FWD ? C_NONE : C_LU);
    chk("ldu2/fwd_b", {30'd0, fwd_b_sel}, FWD ? 2 : 0);

    // taken branch overrides the load-use stall and clears the selects
    clear_in();
    ex_wr = 5'd7; ex_we = 1'b1; ex_is_load = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    ex_br_taken = 1'b1;
    step("br", C_BR);
    chk("br/fwd_b", {30'd0, fwd_b_sel}, 0);

    // memory wait: three frozen cycles, selects held, then release on ack
    do_reset();
    ex_wr = 5'd5; ex_we = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    step("pre", FWD ? C_NONE : C_LU);
    mem_req = 1'b1; mem_ack = 1'b0; ex_br_taken = 1'b1;
    step("frz1", C_FREEZE);
    chk("frz1/fwd_a", {30'd0, fwd_a_sel}, FWD ? 1 : 0);
    ex_br_taken = 1'b0; ex_we = 1'b0; id_use_rs1 = 1'b0;
    step("frz2", C_FREEZE);
    step("frz3", C_FREEZE);
    chk("frz3/fwd_a", {30'd0, fwd_a_sel}, FWD ? 1 : 0);
    chk("frz3/scnt_abs", {16'd0, stall_cnt}, FWD ? 3 : 4);
    mem_ack = 1'b1;
    step("ack", C_NONE);
    chk("ack/fwd_a", {30'd0, fwd_a_sel}, 0);
    step("req_ack", C_NONE);
    mem_req = 1'b0; mem_ack = 1'b0;
    step("run", C_NONE);

    // reset in the middle of a memory wait returns to RUN
    mem_req = 1'b1;
    step("mw", C_FREEZE);
    do_reset();
    step("mw_rst", C_NONE);

    // timeout: ERR after 255 wait cycles following the entry cycle
    mem_req = 1'b1; mem_ack = 1'b0;
    #1;
    chk("tmo/ctl0", {25'd0, ctl}, {25'd0, C_FREEZE});
    for (int i = 0; i < 255; i++) begin
      @(posedge clk);
      exp_sc++;
    end
    #1;
    chk("tmo/early", {31'd0, mem_timeout}, 0);
    chk("tmo/scnt", {16'd0, stall_cnt}, exp_sc);
    @(posedge clk);
    exp_sc++;
    #1;
    chk("tmo/set", {31'd0, mem_timeout}, 1);
    mem_req = 1'b0; mem_ack = 1'b1; ex_br_taken = 1'b1;
    step("err", C_FREEZE);
    chk("err/tmo", {31'd0, mem_timeout}, 1);
    do_reset();
    chk("err_rst/tmo",  {31'd0, mem_timeout}, 0);
    chk("err_rst/scnt", {16'd0, stall_cnt}, 0);
    step("err_rst", C_NONE);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk, rst.
REQ-002 clk  in  1  pipeline clock, all state on rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 id_rs1, id_rs2  in  5 each  ID-stage source register indices.
REQ-005 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
REQ-006 ex_wr  in  5; ex_we  in  1; ex_is_load  in  1  EX-stage destination, write enable, load flag.
REQ-007 mem_wr  in  5; mem_we  in  1  MEM-stage destination, write enable.
REQ-008 ex_br_taken  in  1  branch/jump resolved taken in EX.
REQ-009 mem_req  in  1; mem_ack  in  1  MEM-stage data-memory request and completion.
REQ-010 fwd_a_sel, fwd_b_sel  out  2 each  registered EX operand selects: 0 regfile, 1 EX/MEM result, 2 MEM/WB result.
REQ-011 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the named register.
REQ-012 if_id_flush, id_ex_flush, mem_wb_bubble  out  1 each  load a NOP into the named register.
REQ-013 mem_timeout  out  1  sticky memory-wait timeout flag.
REQ-014 stall_cnt  out  16  cycles with pc_stall=1.

Function
REQ-015 Match(rs, wr, we, use) SHALL be true only for use=1, we=1, wr!=0 and rs==wr.
REQ-016 Load-use hazard: ex_is_load and Match(id_rs1|id_rs2, ex_wr, ex_we) -> pc_stall, if_id_stall, id_ex_flush all 1 same cycle.
REQ-017 Branch flush: ex_br_taken=1 -> if_id_flush=1, id_ex_flush=1, pc_stall=0; overrides load-use stall that cycle.
REQ-018 Memory wait: mem_req=1 and mem_ack=0 -> freeze: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble = 1; all flushes 0; overrides REQ-016/017.
REQ-019 mem_req=1 with mem_ack=1 same cycle SHALL cause no freeze.
REQ-020 FSM states RUN, MEM_WAIT, ERR; RUN->MEM_WAIT on freeze condition; MEM_WAIT->RUN on mem_ack=1; MEM_WAIT->ERR when wait counter reaches 255 without ack.
REQ-021 Wait counter 8-bit: cleared in RUN, +1 each MEM_WAIT cycle with mem_ack=0.
REQ-022 ERR: mem_timeout=1, freeze outputs of REQ-018 held 1 regardless of inputs, exit only by rst.
REQ-023 fwd_x_sel update every non-frozen cycle: 1 if Match(id_rsx, ex_wr, ex_we), else 2 if Match(id_rsx, mem_wr, mem_we), else 0; EX priority over MEM.
REQ-024 fwd_x_sel SHALL load 0 when id_ex_flush=1 and hold value while frozen.
REQ-025 stall_cnt +1 per cycle with pc_stall=1, saturates at 0xFFFF.
REQ-026 All stall/flush outputs combinational from state and inputs, no added latency.

Reset
REQ-027 On rst: state RUN, wait counter 0, fwd_a_sel=fwd_b_sel=0, mem_timeout=0, stall_cnt=0; rst mid-MEM_WAIT or in ERR returns to RUN next cycle.

Configuration
REQ-028 Macro PIPE_HAZARD_CTRL_FWD_EN defined: forwarding per REQ-023, stall only on load-use.
REQ-029 Macro undefined: fwd_a_sel=fwd_b_sel=0 constant; any Match against EX or MEM writer (load or not) stalls per REQ-016, repeating each cycle until cleared; register file write-first covers WB.

Structure
REQ-030 Package pipe_ctrl_pkg SHALL hold fwd-select encodings, FSM state enum, timeout constant 255.
REQ-031 One sub-module hazard_match (REQ-015 comparator), instantiated per source/writer pair.

Verification
REQ-032 FWD_EN: EX add x5 we=1, ID reads rs1=x5 -> next cycle fwd_a_sel=1, no stall.
REQ-033 EX lw x7, ID reads rs2=x7 -> 1 cycle pc_stall=1, id_ex_flush=1; next cycle fwd_b_sel=2.
REQ-034 Load-use plus ex_br_taken=1 same cycle -> if_id_flush=1, id_ex_flush=1, pc_stall=0.
REQ-035 mem_req=1, mem_ack low 3 cycles -> 3 freeze cycles, stall_cnt=3, then RUN.
REQ-036 mem_req=1, mem_ack held 0 -> mem_timeout=1 after 255 wait cycles, frozen until rst; writer x0 never matches.
